window_gen_3x3: RTL and testbench
=================================

# window_gen_3x3

Raster-to-window generator for the 3x3 Gaussian blur datapath. It accepts a row-major 8-bit pixel stream one pixel per accepted cycle and buffers the two previous image rows. For every input pixel whose full 3x3 neighbourhood is available, it emits that neighbourhood as nine parallel pixels on px_1..px_9, which feed the blur kernel directly. The block has no backpressure, matching the stall-free blur pipeline downstream.

## Interface
- IMG_W, 128, pixels per row (3..1024)
- IMG_H, 128, rows per frame (3..1024)
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- in_valid  in  1  pixel present this cycle; accepted on the rising edge
- in_sof  in  1  qualified by in_valid; marks pixel (0,0) of a frame
- in_px  in  8  input pixel
- px_1..px_9  out  8 each  window, row-major: px_1 top-left, px_5 centre, px_9 bottom-right
- win_valid  out  1  one-cycle strobe, window on px_1..px_9 is valid
- win_last  out  1  with win_valid, final window of the frame
- frame_done  out  1  one-cycle pulse after pixel (IMG_H-1, IMG_W-1) is accepted

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the next pixel. They advance only on accepted pixels. col wraps to 0 and increments row. At (IMG_H-1, IMG_W-1), both return to 0.
- FSM:
  - IDLE → FILL on any accepted pixel, which is taken as (0,0) whether or not in_sof is set.
  - FILL (row < 2) → ACTIVE when row becomes 2.
  - ACTIVE → IDLE on the last pixel of the frame, with frame_done pulsing.
  - Accepted in_sof in FILL or ACTIVE restarts the frame: that pixel becomes (0,0), state goes to FILL, and no frame_done is issued.
- Two line buffers of IMG_W × 8 bits, both indexed by col:
  - lb0 holds row r-1 and lb1 holds row r-2.
  - On acceptance, read both at col, write in_px into lb0[col], and write the old lb0[col] into lb1[col].
- Window registers: a 3×3 shift register. On acceptance, columns shift left and the new right column is {lb1[col], lb0[col], in_px} (top to bottom).
- An input at (r,c) produces a window when r ≥ 2 and c ≥ 2. The window covers rows r-2..r and cols c-2..c (centre at r-1, c-1).
- Windows per frame: (IMG_W-2)·(IMG_H-2). No border/padding windows are produced.
- win_last is asserted with the window for (IMG_H-1, IMG_W-1).
- Line-buffer contents are never cleared. Stale data is masked by the row ≥ 2 qualification.

## Timing
- Reset values:
  - px_1..px_9 = 0
  - win_valid = 0, win_last = 0, frame_done = 0
  - col = row = 0, state IDLE
- Latency: when a pixel is accepted at edge k, its window, win_valid, win_last and frame_done are registered at edge k and high for exactly one cycle.
- When in_valid is low: no state change, px_* hold their values, and win_valid, win_last and frame_done are 0.
- Back-to-back frames are supported. The first pixel of frame N+1 may arrive the cycle after the last pixel of frame N.
- Reset mid-frame aborts immediately with no output strobes. The next accepted pixel is (0,0).
- in_sof on the last pixel of a frame: treated as a restart, with no frame_done and no win_last.

## Structure
- Shared package win_pkg, containing:
  - PX_W = 8
  - the state enum {IDLE, FILL, ACTIVE}
  - a window typedef (array of 9 × PX_W)
- Sub-module line_buffer:
  - parameters DEPTH, WIDTH
  - single port, synchronous write, asynchronous read at the same index
  - instantiated twice, or once with 2·WIDTH width holding both rows
- Counters, FSM and the 3×3 register live in the top module.

## Test plan
- IMG_W=8, IMG_H=6; continuous frame of in_px = 16·r + c:
  - first window (input at 2,2) gives px_1..px_9 = 0,1,2,16,17,18,32,33,34
  - exactly 24 win_valid strobes
  - win_last and frame_done on the window for input (5,7)
- Same frame with in_valid deasserted every third cycle:
  - identical 24 windows in the same order
  - px_* held stable during gaps
- Restart mid-frame:
  - send 3 rows, then in_sof with a full new frame of in_px = 100 + c
  - first window after restart is all 100/101/102 columns
  - no frame_done for the aborted frame
- Reset mid-frame:
  - assert reset during row 3
  - all outputs read 0
  - a subsequent frame produces the correct 24 windows with no stale data
- Two back-to-back frames with no gap:
  - 48 windows total
  - frame_done twice
  - the first window of frame 2 contains only frame-2 pixels
- Minimum size IMG_W=3, IMG_H=3, pixels 1..9:
  - a single window 1..9 with win_valid, win_last and frame_done all on the same cycle

Source files
------------

// File: rtl/win_pkg.sv
// Shared definitions for the 3x3 window generator: pixel width, the
// frame-tracking state encoding and the packed 3x3 window type.
package win_pkg;

  localparam int PX_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // Element 0 is the top-left pixel, element 8 the bottom-right pixel.
  typedef logic [8:0][PX_W-1:0] window_t;

endpackage

// File: rtl/line_buffer.sv
// Single-port line memory: synchronous write, asynchronous read at the
// same address. Contents are never cleared; consumers must mask stale data.
module line_buffer #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry when enabled; the read below sees the old value.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-to-window generator. Tracks the raster position of each accepted
// pixel, keeps the two previous rows in a combined line buffer and shifts a
// 3x3 register so every pixel at row>=2, col>=2 presents its neighbourhood.
import win_pkg::*;

module window_gen_3x3 #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [PX_W-1:0] in_px,
  output logic [PX_W-1:0] px_1,
  output logic [PX_W-1:0] px_2,
  output logic [PX_W-1:0] px_3,
  output logic [PX_W-1:0] px_4,
  output logic [PX_W-1:0] px_5,
  output logic [PX_W-1:0] px_6,
  output logic [PX_W-1:0] px_7,
  output logic [PX_W-1:0] px_8,
  output logic [PX_W-1:0] px_9,
  output logic            win_valid,
  output logic            win_last,
  output logic            frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  window_t       win_q, win_d;
  logic          winValid_q, winValid_d;
  logic          winLast_q, winLast_d;
  logic          frameDone_q, frameDone_d;

  logic                startFrame;
  logic [CW-1:0]       posCol;
  logic [RW-1:0]       posRow;
  logic                isLast;
  logic                winHit;
  logic [2*PX_W-1:0]   lbRd;
  logic [2*PX_W-1:0]   lbWr;
  logic [PX_W-1:0]     lb0Rd;
  logic [PX_W-1:0]     lb1Rd;

  // Lower half holds row r-1, upper half row r-2; both share one address.
  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (2 * PX_W)
  ) u_lines (
    .clk     (clk),
    .we_i    (in_valid),
    .addr_i  (posCol),
    .wdata_i (lbWr),
    .rdata_o (lbRd)
  );

  assign lb0Rd = lbRd[PX_W-1:0];
  assign lb1Rd = lbRd[2*PX_W-1:PX_W];
  assign lbWr  = {lb0Rd, in_px};

  // Resolve where the current pixel sits; an idle block or in_sof forces (0,0).
  always_comb begin
    startFrame = (state_q == IDLE) || in_sof;
    posCol     = startFrame ? '0 : col_q;
    posRow     = startFrame ? '0 : row_q;
    isLast     = (posCol == COL_LAST) && (posRow == ROW_LAST);
    winHit     = (posCol >= CW'(2)) && (posRow >= RW'(2));
  end

  // Next position, state, window contents and output strobes.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    winValid_d  = 1'b0;
    winLast_d   = 1'b0;
    frameDone_d = 1'b0;
    if (in_valid) begin
      if (isLast) begin
        col_d = '0;
        row_d = '0;
      end else if (posCol == COL_LAST) begin
        col_d = '0;
        row_d = posRow + RW'(1);
      end else begin
        col_d = posCol + CW'(1);
        row_d = posRow;
      end

      if (isLast) begin
        state_d = IDLE;
      end else if (row_d >= RW'(2)) begin
        state_d = ACTIVE;
      end else begin
        state_d = FILL;
      end

      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1Rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0Rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_px;

      winValid_d  = winHit;
      winLast_d   = winHit && isLast;
      frameDone_d = isLast;
    end
  end

  // Register everything; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      winValid_q  <= 1'b0;
      winLast_q   <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      winValid_q  <= winValid_d;
      winLast_q   <= winLast_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign px_1       = win_q[0];
  assign px_2       = win_q[1];
  assign px_3       = win_q[2];
  assign px_4       = win_q[3];
  assign px_5       = win_q[4];
  assign px_6       = win_q[5];
  assign px_7       = win_q[6];
  assign px_8       = win_q[7];
  assign px_9       = win_q[8];
  assign win_valid  = winValid_q;
  assign win_last   = winLast_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3. An 8x6 instance is driven with
// directed and random pixel streams and compared against an image-array
// model; a 3x3 instance covers the minimum frame size.
module tb_window_gen_3x3;

  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN;
  logic       inValid, inSof;
  logic [7:0] inPx;
  logic [7:0] px1, px2, px3, px4, px5, px6, px7, px8, px9;
  logic       winValid, winLast, frameDone;

  logic       minValid, minSof;
  logic [7:0] minPx;
  logic [7:0] mp1, mp2, mp3, mp4, mp5, mp6, mp7, mp8, mp9;
  logic       minWinValid, minWinLast, minFrameDone;

  logic [71:0] dutWin, minWin;
  assign dutWin = {px1, px2, px3, px4, px5, px6, px7, px8, px9};
  assign minWin = {mp1, mp2, mp3, mp4, mp5, mp6, mp7, mp8, mp9};

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(resetN), .in_valid(inValid), .in_sof(inSof), .in_px(inPx),
    .px_1(px1), .px_2(px2), .px_3(px3), .px_4(px4), .px_5(px5),
    .px_6(px6), .px_7(px7), .px_8(px8), .px_9(px9),
    .win_valid(winValid), .win_last(winLast), .frame_done(frameDone)
  );

  window_gen_3x3 #(.IMG_W(3), .IMG_H(3)) dutMin (
    .clk(clk), .reset(resetN), .in_valid(minValid), .in_sof(minSof), .in_px(minPx),
    .px_1(mp1), .px_2(mp2), .px_3(mp3), .px_4(mp4), .px_5(mp5),
    .px_6(mp6), .px_7(mp7), .px_8(mp8), .px_9(mp9),
    .win_valid(minWinValid), .win_last(minWinLast), .frame_done(minFrameDone)
  );

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: raster position, current frame image, expected window.
  int          mRow, mCol;
  bit          mIdle;
  logic [7:0]  img [H][W];
  logic [71:0] expWin;
  bit          holdValid;
  int          winCount, doneCount, lastCount;
  logic [71:0] firstWin;
  bit          firstSeen;

  task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] pixelFor(input int mode, input int r, input int c);
    if (mode == 0) return 8'(16 * r + c);
    if (mode == 1) return 8'(100 + c);
    return 8'($urandom);
  endfunction

  task automatic clearCounts();
    winCount = 0; doneCount = 0; lastCount = 0; firstSeen = 0; firstWin = '0;
  endtask

  // Drive one cycle on the 8x6 instance, step the model and compare.
  task automatic applyStimulus(input logic v, input logic sof, input logic [7:0] px);
    int r, c;
    bit last, eValid, eLast, eDone;
    @(negedge clk);
    inValid = v; inSof = sof; inPx = px;
    @(posedge clk);
    #1;
    eValid = 0; eLast = 0; eDone = 0;
    if (v) begin
      if (mIdle || sof) begin r = 0; c = 0; end
      else begin r = mRow; c = mCol; end
      img[r][c] = px;
      last   = (r == H - 1) && (c == W - 1);
      eValid = (r >= 2) && (c >= 2);
      eLast  = eValid && last;
      eDone  = last;
      if (eValid)
        expWin = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                  img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                  img[r][c-2],   img[r][c-1],   img[r][c]};
      holdValid = eValid;
      if (last) begin
        mIdle = 1; mRow = 0; mCol = 0;
      end else begin
        mIdle = 0;
        if (c == W - 1) begin mCol = 0; mRow = r + 1; end
        else begin mCol = c + 1; mRow = r; end
      end
    end
    checkOutput("win_valid", 72'(winValid), 72'(eValid));
    checkOutput("win_last", 72'(winLast), 72'(eLast));
    checkOutput("frame_done", 72'(frameDone), 72'(eDone));
    if (eValid) checkOutput("window", dutWin, expWin);
    else if (!v && holdValid) checkOutput("window_hold", dutWin, expWin);
    if (winValid) begin
      winCount++;
      if (!firstSeen) begin firstSeen = 1; firstWin = dutWin; end
    end
    if (frameDone) doneCount++;
    if (winLast) lastCount++;
  endtask

  // Send count pixels of a frame from (0,0), optionally idling every gapEvery-th cycle.
  task automatic sendPixels(input int mode, input int count, input int gapEvery);
    int n;
    n = 0;
    for (int k = 0; k < count; k++) begin
      if (gapEvery > 0 && (n % gapEvery) == gapEvery - 1) begin
        applyStimulus(1'b0, 1'b0, 8'($urandom));
        n++;
      end
      applyStimulus(1'b1, k == 0, pixelFor(mode, k / W, k % W));
      n++;
    end
  endtask

  // Pulse reset between clock edges and confirm both instances clear at once.
  task automatic resetDut();
    @(negedge clk);
    resetN = 0; inValid = 0; inSof = 0; minValid = 0; minSof = 0;
    #1;
    mIdle = 1; mRow = 0; mCol = 0; expWin = '0; holdValid = 1;
    checkOutput("rst_window", dutWin, 72'd0);
    checkOutput("rst_win_valid", 72'(winValid), 72'd0);
    checkOutput("rst_win_last", 72'(winLast), 72'd0);
    checkOutput("rst_frame_done", 72'(frameDone), 72'd0);
    checkOutput("rst_min_window", minWin, 72'd0);
    checkOutput("rst_min_strobes", 72'({minWinValid, minWinLast, minFrameDone}), 72'd0);
    @(negedge clk);
    resetN = 1;
  endtask

  // Drive one pixel on the 3x3 instance and check its strobes.
  task automatic applyMin(input logic v, input logic sof, input logic [7:0] px, input logic expStrobe);
    @(negedge clk);
    minValid = v; minSof = sof; minPx = px;
    @(posedge clk);
    #1;
    checkOutput("min_win_valid", 72'(minWinValid), 72'(expStrobe));
    checkOutput("min_win_last", 72'(minWinLast), 72'(expStrobe));
    checkOutput("min_frame_done", 72'(minFrameDone), 72'(expStrobe));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1; inValid = 0; inSof = 0; inPx = 0;
    minValid = 0; minSof = 0; minPx = 0;
    resetDut();

    // Continuous frame of 16r+c.
    clearCounts();
    sendPixels(0, W * H, 0);
    checkOutput("t1_first_window", firstWin, 72'h00_01_02_10_11_12_20_21_22);
    checkOutput("t1_win_count", 72'(winCount), 72'd24);
    checkOutput("t1_done_count", 72'(doneCount), 72'd1);
    checkOutput("t1_last_count", 72'(lastCount), 72'd1);

    // Same frame with an idle cycle every third cycle.
    clearCounts();
    sendPixels(0, W * H, 3);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t2_first_window", firstWin, 72'h00_01_02_10_11_12_20_21_22);
    checkOutput("t2_win_count", 72'(winCount), 72'd24);
    checkOutput("t2_done_count", 72'(doneCount), 72'd1);

    // Restart after three rows with a new frame of 100+c.
    clearCounts();
    sendPixels(0, 3 * W, 0);
    checkOutput("t3_partial_windows", 72'(winCount), 72'd6);
    firstSeen = 0;
    sendPixels(1, W * H, 0);
    checkOutput("t3_restart_window", firstWin, 72'h64_65_66_64_65_66_64_65_66);
    checkOutput("t3_win_count", 72'(winCount), 72'd30);
    checkOutput("t3_done_count", 72'(doneCount), 72'd1);

    // Reset during row 3, then a random frame must show no stale data.
    sendPixels(0, 3 * W + 4, 0);
    resetDut();
    clearCounts();
    sendPixels(2, W * H, 0);
    checkOutput("t4_win_count", 72'(winCount), 72'd24);
    checkOutput("t4_done_count", 72'(doneCount), 72'd1);

    // Two frames back to back, second one random.
    clearCounts();
    sendPixels(0, W * H, 0);
    sendPixels(2, W * H, 0);
    checkOutput("t5_win_count", 72'(winCount), 72'd48);
    checkOutput("t5_done_count", 72'(doneCount), 72'd2);
    checkOutput("t5_last_count", 72'(lastCount), 72'd2);

    // Random valid gaps, random pixels and occasional restarts.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) resetDut();
      applyStimulus(($urandom % 4) != 0, ($urandom % 60) == 0, 8'($urandom));
    end
    applyStimulus(1'b0, 1'b0, 8'h00);

    // Minimum 3x3 frame of pixels 1..9.
    for (int k = 1; k <= 9; k++) begin
      applyMin(1'b1, k == 1, 8'(k), k == 9);
    end
    checkOutput("min_window", minWin, 72'h01_02_03_04_05_06_07_08_09);
    applyMin(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("min_window_hold", minWin, 72'h01_02_03_04_05_06_07_08_09);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
